// File: rtl/sysid_check_master.sv
`default_nettype none
// ============================================================================
//  Module   : sysid_check_master
//  Brief    : Avalon-MM read master that fetches the system-ID word (addr 0)
//             and the build timestamp (addr 1). Both are compared against
//             build-time constants. Captured values and pass/fail/timeout
//             status are held for software and display logic.
//  Revision : 1.0 - initial release
// ============================================================================
module sysid_check_master #(
    parameter logic [31:0] EXPECTED_ID    = 32'hACD51302,
    parameter logic [31:0] EXPECTED_TS    = 32'h560CC9C4,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic        AUTO_START     = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] sysid_id,
    output logic [31:0] sysid_ts
);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_ID_REQ  = 3'd1;
    localparam logic [2:0] c_ST_ID_WAIT = 3'd2;
    localparam logic [2:0] c_ST_TS_REQ  = 3'd3;
    localparam logic [2:0] c_ST_TS_WAIT = 3'd4;
    localparam logic [2:0] c_ST_DONE    = 3'd5;

    // Last timer value at which a read may still complete.
    localparam logic [15:0] c_TIMER_LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [15:0] r_timer;
    logic        r_auto_pend;
    logic        r_id_ok;
    logic        r_ts_ok;
    logic        r_timeout;
    logic [31:0] r_sysid_id;
    logic [31:0] r_sysid_ts;

    logic w_in_req;
    logic w_in_wait;
    logic w_active;
    logic w_is_ts;
    logic w_capture;
    logic w_expire;
    logic w_launch;
    logic w_enter_req;

    // Decode of the current phase; a zero-latency slave may return data in
    // the very cycle the request is accepted, so that counts as a capture.
    always_comb begin
        w_in_req  = (r_state == c_ST_ID_REQ) || (r_state == c_ST_TS_REQ);
        w_in_wait = (r_state == c_ST_ID_WAIT) || (r_state == c_ST_TS_WAIT);
        w_active  = w_in_req || w_in_wait;
        w_is_ts   = (r_state == c_ST_TS_REQ) || (r_state == c_ST_TS_WAIT);
        w_capture = avm_readdatavalid &&
                    (w_in_wait || (w_in_req && !avm_waitrequest));
        w_expire  = w_active && !w_capture && (r_timer == c_TIMER_LIMIT);
    end

    // Next-state selection; capture beats timeout, timeout beats accept.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start || r_auto_pend) w_state_nxt = c_ST_ID_REQ;
            end
            c_ST_ID_REQ: begin
                if (w_capture)             w_state_nxt = c_ST_TS_REQ;
                else if (w_expire)         w_state_nxt = c_ST_DONE;
                else if (!avm_waitrequest) w_state_nxt = c_ST_ID_WAIT;
            end
            c_ST_ID_WAIT: begin
                if (w_capture)     w_state_nxt = c_ST_TS_REQ;
                else if (w_expire) w_state_nxt = c_ST_DONE;
            end
            c_ST_TS_REQ: begin
                if (w_capture || w_expire) w_state_nxt = c_ST_DONE;
                else if (!avm_waitrequest) w_state_nxt = c_ST_TS_WAIT;
            end
            c_ST_TS_WAIT: begin
                if (w_capture || w_expire) w_state_nxt = c_ST_DONE;
            end
            c_ST_DONE: begin
                if (start) w_state_nxt = c_ST_ID_REQ;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Entry strobes: a fresh check starts, or a new per-read timer window opens.
    always_comb begin
        w_launch    = (w_state_nxt == c_ST_ID_REQ) &&
                      ((r_state == c_ST_IDLE) || (r_state == c_ST_DONE));
        w_enter_req = ((w_state_nxt == c_ST_ID_REQ) && (r_state != c_ST_ID_REQ)) ||
                      ((w_state_nxt == c_ST_TS_REQ) && (r_state != c_ST_TS_REQ));
    end

    // State, per-read timer, captured words and status flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_timer     <= '0;
            r_auto_pend <= AUTO_START;
            r_id_ok     <= 1'b0;
            r_ts_ok     <= 1'b0;
            r_timeout   <= 1'b0;
            r_sysid_id  <= '0;
            r_sysid_ts  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_auto_pend <= 1'b0;

            if (w_enter_req)   r_timer <= '0;
            else if (w_active) r_timer <= r_timer + 16'd1;

            if (w_launch) begin
                r_id_ok   <= 1'b0;
                r_ts_ok   <= 1'b0;
                r_timeout <= 1'b0;
            end

            if (w_capture && !w_is_ts) begin
                r_sysid_id <= avm_readdata;
                r_id_ok    <= (avm_readdata == EXPECTED_ID);
            end

            if (w_capture && w_is_ts) begin
                r_sysid_ts <= avm_readdata;
                r_ts_ok    <= (avm_readdata == EXPECTED_TS);
            end

            if (w_expire) r_timeout <= 1'b1;
        end
    end

    // Bus and status outputs are pure state decodes, so they only move on
    // the edges where the state moves (never while stalled, except on abort).
    always_comb begin
        avm_read    = w_in_req;
        avm_address = (r_state == c_ST_TS_REQ);
        busy        = w_active;
        done        = (r_state == c_ST_DONE);
        id_ok       = r_id_ok;
        ts_ok       = r_ts_ok;
        timeout     = r_timeout;
        sysid_id    = r_sysid_id;
        sysid_ts    = r_sysid_ts;
    end

endmodule
`default_nettype wire

// File: tb/tb_sysid_check_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sysid_check_master
//  Brief    : Randomised bench for sysid_check_master. A behavioural Avalon
//             slave with per-address stall/latency/data settings drives the
//             DUT; a transaction-level model predicts the outcome of each
//             check (flags, captured words, busy cycles, accepted reads).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sysid_check_master;

    localparam logic [31:0] c_EXP_ID = 32'hACD51302;
    localparam logic [31:0] c_EXP_TS = 32'h560CC9C4;
    localparam int          c_TMO    = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata = '0;
    logic        avm_waitrequest = 1'b0;
    logic        avm_readdatavalid = 1'b0;
    logic        busy;
    logic        done;
    logic        id_ok;
    logic        ts_ok;
    logic        timeout;
    logic [31:0] sysid_id;
    logic [31:0] sysid_ts;

    // Slave configuration, indexed by word address (owned by the main thread).
    int          cfg_stall [2];
    int          cfg_lat   [2];
    logic [31:0] cfg_data  [2];
    int          inject_req = 0;

    // Bus statistics (owned by the bus process; main thread takes deltas).
    int          busy_cnt  = 0;
    int          hold_viol = 0;
    int          acc_cnt   = 0;
    logic [7:0]  acc_bits  = '0;

    // Reference-model state carried between checks.
    logic [31:0] m_id = '0;
    logic [31:0] m_ts = '0;
    logic        m_id_ok, m_ts_ok, m_tmo;

    int n_checks = 0;
    int n_pass   = 0;

    sysid_check_master #(
        .EXPECTED_ID    (c_EXP_ID),
        .EXPECTED_TS    (c_EXP_TS),
        .TIMEOUT_CYCLES (c_TMO),
        .AUTO_START     (1'b1)
    ) u_dut (
        .clock             (clock),
        .reset             (reset),
        .start             (start),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_readdata      (avm_readdata),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdatavalid (avm_readdatavalid),
        .busy              (busy),
        .done              (done),
        .id_ok             (id_ok),
        .ts_ok             (ts_ok),
        .timeout           (timeout),
        .sysid_id          (sysid_id),
        .sysid_ts          (sysid_ts)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Behavioural slave plus bus monitor, evaluated mid-cycle.
    initial begin : p_bus
        int          stall_cnt;
        int          pend_cnt;
        int          inject_seen;
        logic [31:0] pend_data;
        logic        prev_read, prev_wr, prev_addr;
        stall_cnt = 0; pend_cnt = 0; inject_seen = 0; pend_data = '0;
        prev_read = 1'b0; prev_wr = 1'b0; prev_addr = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset && busy) busy_cnt++;
            if (!reset && prev_read && prev_wr && !timeout &&
                (!avm_read || avm_address != prev_addr)) hold_viol++;
            avm_readdatavalid = 1'b0;
            avm_readdata      = $urandom;
            if (reset) begin
                stall_cnt = 0; pend_cnt = 0; avm_waitrequest = 1'b0;
            end else begin
                if (pend_cnt > 0) begin
                    pend_cnt--;
                    if (pend_cnt == 0) begin
                        avm_readdatavalid = 1'b1;
                        avm_readdata      = pend_data;
                    end
                end
                if (inject_req != inject_seen) begin
                    inject_seen       = inject_req;
                    avm_readdatavalid = 1'b1;
                    avm_readdata      = 32'hDEADBEEF;
                end
                if (avm_read) begin
                    if (stall_cnt < cfg_stall[avm_address]) begin
                        avm_waitrequest = 1'b1;
                        stall_cnt++;
                    end else begin
                        avm_waitrequest = 1'b0;
                        stall_cnt = 0;
                        acc_cnt++;
                        acc_bits = {acc_bits[6:0], avm_address};
                        if (cfg_lat[avm_address] == 0) begin
                            avm_readdatavalid = 1'b1;
                            avm_readdata      = cfg_data[avm_address];
                        end else begin
                            pend_cnt  = cfg_lat[avm_address];
                            pend_data = cfg_data[avm_address];
                        end
                    end
                end else begin
                    avm_waitrequest = 1'b0;
                    stall_cnt = 0;
                end
            end
            prev_read = avm_read;
            prev_wr   = avm_waitrequest;
            prev_addr = avm_address;
        end
    end

    // Transaction-level prediction: each read costs stall+1+latency cycles,
    // and a read that cannot finish within the timeout window ends the check.
    task automatic model_run(output int e_busy, output int e_acc, output logic [7:0] e_bits);
        int n;
        e_busy = 0; e_acc = 0; e_bits = '0;
        m_id_ok = 1'b0; m_ts_ok = 1'b0; m_tmo = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n = cfg_stall[k] + 1 + cfg_lat[k];
            if (cfg_stall[k] + 1 <= c_TMO) begin
                e_acc++;
                e_bits = {e_bits[6:0], 1'(k)};
            end
            if (n > c_TMO) begin
                m_tmo  = 1'b1;
                e_busy = e_busy + c_TMO;
                break;
            end
            e_busy = e_busy + n;
            if (k == 0) begin
                m_id    = cfg_data[0];
                m_id_ok = (cfg_data[0] == c_EXP_ID);
            end else begin
                m_ts    = cfg_data[1];
                m_ts_ok = (cfg_data[1] == c_EXP_TS);
            end
        end
    endtask

    // Run one check (explicit start or auto-start) and compare with the model.
    task automatic do_check(input bit send_start, input bit mid_pulse);
        int         e_busy, e_acc, b0, a0, h0;
        logic [7:0] e_bits, mask;
        bit         fin;
        model_run(e_busy, e_acc, e_bits);
        b0 = busy_cnt; a0 = acc_cnt; h0 = hold_viol;
        if (send_start) start = 1'b1;
        @(posedge clock); #2;
        start = 1'b0;
        chk("entry_flags", {27'd0, busy, done, id_ok, ts_ok, timeout}, 32'h10);
        fin = 1'b0;
        for (int i = 0; i < 200 && !fin; i++) begin
            if (done) fin = 1'b1;
            else begin
                if (mid_pulse && i == 1) start = 1'b1;
                @(posedge clock); #2;
                start = 1'b0;
            end
        end
        chk("done_wait", {31'd0, fin}, 32'd1);
        chk("busy_end", {31'd0, busy}, 32'd0);
        chk("id_ok", {31'd0, id_ok}, {31'd0, m_id_ok});
        chk("ts_ok", {31'd0, ts_ok}, {31'd0, m_ts_ok});
        chk("timeout", {31'd0, timeout}, {31'd0, m_tmo});
        chk("sysid_id", sysid_id, m_id);
        chk("sysid_ts", sysid_ts, m_ts);
        chk("busy_cycles", 32'(busy_cnt - b0), 32'(e_busy));
        chk("accepts", 32'(acc_cnt - a0), 32'(e_acc));
        mask = 8'((1 << e_acc) - 1);
        chk("accept_addrs", {24'd0, acc_bits & mask}, {24'd0, e_bits});
        chk("hold_rule", 32'(hold_viol - h0), 32'd0);
        repeat (8) begin @(posedge clock); #2; end
    endtask

    task automatic set_cfg(input int s0, input int l0, input logic [31:0] d0,
                           input int s1, input int l1, input logic [31:0] d1);
        cfg_stall[0] = s0; cfg_lat[0] = l0; cfg_data[0] = d0;
        cfg_stall[1] = s1; cfg_lat[1] = l1; cfg_data[1] = d1;
    endtask

    initial begin : p_main
        set_cfg(0, 0, c_EXP_ID, 0, 0, c_EXP_TS);
        repeat (3) @(posedge clock);
        #2;
        chk("rst_flags", {25'd0, busy, done, id_ok, ts_ok, timeout, avm_read, avm_address}, 32'd0);
        chk("rst_id", sysid_id, 32'd0);
        chk("rst_ts", sysid_ts, 32'd0);

        // Auto-start with a zero-wait, zero-latency slave.
        reset = 1'b0;
        do_check(1'b0, 1'b0);

        // Wrong ID word.
        set_cfg(0, 0, 32'h12345678, 0, 0, c_EXP_TS);
        do_check(1'b1, 1'b0);

        // Stalls of 5 and read latency of 2 on both reads.
        set_cfg(5, 2, c_EXP_ID, 5, 2, c_EXP_TS);
        do_check(1'b1, 1'b0);

        // Waitrequest stuck high, then a stray readdatavalid in DONE.
        set_cfg(1000, 0, c_EXP_ID, 0, 0, c_EXP_TS);
        do_check(1'b1, 1'b0);
        inject_req++;
        repeat (4) begin @(posedge clock); #2; end
        chk("stray_id", sysid_id, m_id);
        chk("stray_flags", {29'd0, done, id_ok, timeout}, 32'h5);

        // Start while busy is ignored; re-check in DONE with a new timestamp.
        set_cfg(3, 1, c_EXP_ID, 3, 1, c_EXP_TS);
        do_check(1'b1, 1'b1);
        cfg_data[1] = c_EXP_TS ^ 32'h1;
        do_check(1'b1, 1'b0);

        // Reset (with a coincident start) while waiting on the timestamp.
        set_cfg(0, 0, c_EXP_ID, 0, 5, c_EXP_TS);
        start = 1'b1;
        @(posedge clock); #2;
        start = 1'b0;
        repeat (2) begin @(posedge clock); #2; end
        chk("ts_wait_state", {30'd0, busy, avm_read}, 32'h2);
        reset = 1'b1;
        start = 1'b1;
        @(posedge clock); #2;
        chk("midrst_flags", {25'd0, busy, done, id_ok, ts_ok, timeout, avm_read, avm_address}, 32'd0);
        chk("midrst_id", sysid_id, 32'd0);
        chk("midrst_ts", sysid_ts, 32'd0);
        reset = 1'b0;
        start = 1'b0;
        m_id = '0;
        m_ts = '0;
        do_check(1'b0, 1'b0);

        // Randomised stall/latency/data mixes, some beyond the timeout window.
        for (int it = 0; it < 20; it++) begin
            set_cfg(int'($urandom_range(0, 12)), int'($urandom_range(0, 5)),
                    ($urandom_range(0, 1) == 1) ? c_EXP_ID : 32'($urandom),
                    int'($urandom_range(0, 12)), int'($urandom_range(0, 5)),
                    ($urandom_range(0, 1) == 1) ? c_EXP_TS : 32'($urandom));
            do_check(1'b1, ($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
